// File: rtl/fma_align_stage.sv
// Addend alignment for a fused multiply-add: two-stage right shift (coarse by 8s, then fine)
// with sticky collection and optional inversion for effective subtraction.
module fma_align_stage #(
    parameter int MANT_W = 24,
    parameter int ALN_W  = 74
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] mant_c,
    input  logic [6:0]        shf_num,
    input  logic [9:0]        exp_tmp,
    input  logic              eff_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ALN_W-1:0]  out_aligned,
    output logic              out_sticky,
    output logic [9:0]        out_exp_tmp,
    output logic              out_sub
);

    localparam int         PAD_W   = ALN_W - MANT_W;
    localparam logic [6:0] SHF_MAX = 7'(ALN_W);

    logic             v1_q, v1_d;
    logic [ALN_W-1:0] data1_q, data1_d;
    logic             stk1_q, stk1_d;
    logic [2:0]       fine1_q, fine1_d;
    logic [9:0]       exp1_q, exp1_d;
    logic             sub1_q, sub1_d;

    logic             v2_q, v2_d;
    logic [ALN_W-1:0] al2_q, al2_d;
    logic             stk2_q, stk2_d;
    logic [9:0]       exp2_q, exp2_d;
    logic             sub2_q, sub2_d;

    logic             ready1, ready2;
    logic [6:0]       shf_c;
    logic [6:0]       coarse_amt;
    logic [ALN_W-1:0] c_ext;
    logic [ALN_W-1:0] coarse_mask;
    logic [ALN_W-1:0] fine_mask;
    logic [ALN_W-1:0] fine_shifted;

    always_comb begin
        ready2 = ~v2_q | out_ready;
        ready1 = ~v1_q | ready2;

        // Clamping to the field width makes every oversize shift discard the whole addend into sticky.
        shf_c        = (shf_num > SHF_MAX) ? SHF_MAX : shf_num;
        coarse_amt   = {shf_c[6:3], 3'b000};
        c_ext        = {mant_c, {PAD_W{1'b0}}};
        coarse_mask  = ~({ALN_W{1'b1}} << coarse_amt);
        fine_mask    = ~({ALN_W{1'b1}} << fine1_q);
        fine_shifted = data1_q >> fine1_q;

        v1_d    = v1_q;
        data1_d = data1_q;
        stk1_d  = stk1_q;
        fine1_d = fine1_q;
        exp1_d  = exp1_q;
        sub1_d  = sub1_q;
        v2_d    = v2_q;
        al2_d   = al2_q;
        stk2_d  = stk2_q;
        exp2_d  = exp2_q;
        sub2_d  = sub2_q;

        if (ready1) begin
            v1_d = in_valid;
            if (in_valid) begin
                data1_d = c_ext >> coarse_amt;
                stk1_d  = |(c_ext & coarse_mask);
                fine1_d = shf_c[2:0];
                exp1_d  = exp_tmp;
                sub1_d  = eff_sub;
            end
        end

        if (ready2) begin
            v2_d = v1_q;
            if (v1_q) begin
                // Sticky is taken from the un-inverted bits; only the aligned field is complemented.
                stk2_d = stk1_q | (|(data1_q & fine_mask));
                al2_d  = sub1_q ? ~fine_shifted : fine_shifted;
                exp2_d = exp1_q;
                sub2_d = sub1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            data1_q <= '0;
            stk1_q  <= 1'b0;
            fine1_q <= '0;
            exp1_q  <= '0;
            sub1_q  <= 1'b0;
            v2_q    <= 1'b0;
            al2_q   <= '0;
            stk2_q  <= 1'b0;
            exp2_q  <= '0;
            sub2_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            data1_q <= data1_d;
            stk1_q  <= stk1_d;
            fine1_q <= fine1_d;
            exp1_q  <= exp1_d;
            sub1_q  <= sub1_d;
            v2_q    <= v2_d;
            al2_q   <= al2_d;
            stk2_q  <= stk2_d;
            exp2_q  <= exp2_d;
            sub2_q  <= sub2_d;
        end
    end

    assign in_ready    = rst_n & ready1;
    assign out_valid   = v2_q;
    assign out_aligned = al2_q;
    assign out_sticky  = stk2_q;
    assign out_exp_tmp = exp2_q;
    assign out_sub     = sub2_q;

endmodule

// File: tb/tb_fma_align_stage.sv
// Directed bench for fma_align_stage: alignment vectors, latency, backpressure and reset flush.
module tb_fma_align_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] mant_c;
    logic [6:0]  shf_num;
    logic [9:0]  exp_tmp;
    logic        eff_sub;
    logic        out_valid;
    logic        out_ready;
    logic [73:0] out_aligned;
    logic        out_sticky;
    logic [9:0]  out_exp_tmp;
    logic        out_sub;

    int errors = 0;
    int checks = 0;

    fma_align_stage #(.MANT_W(24), .ALN_W(74)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mant_c(mant_c), .shf_num(shf_num), .exp_tmp(exp_tmp), .eff_sub(eff_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_aligned(out_aligned),
        .out_sticky(out_sticky), .out_exp_tmp(out_exp_tmp), .out_sub(out_sub)
    );

    always #5 clk = ~clk;

    // Drives one operand into an empty pipe and captures the first result; lat = cycles to out_valid.
    task automatic send_one(input logic [23:0] m, input logic [6:0] s, input logic [9:0] e,
                            input logic sb, output logic [73:0] al, output logic st,
                            output logic [9:0] eo, output logic so, output int lat);
        @(negedge clk);
        mant_c = m; shf_num = s; exp_tmp = e; eff_sub = sb;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        al = out_aligned; st = out_sticky; eo = out_exp_tmp; so = out_sub;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mant_c = '0; shf_num = '0; exp_tmp = '0; eff_sub = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_aligned !== 74'h0 || out_sticky !== 1'b0 || out_exp_tmp !== 10'h0 || out_sub !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got al=%h st=%b ex=%h sb=%b exp all 0", out_aligned, out_sticky, out_exp_tmp, out_sub);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_align();
        logic [73:0] al;
        logic        st, so;
        logic [9:0]  eo;
        int          lat;

        send_one(24'h800000, 7'd0, 10'h0AA, 1'b0, al, st, eo, so, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL latency got=%0d exp=2", lat); end
        checks++;
        if (al !== 74'h2_0000_0000_0000_0000_00 || st !== 1'b0)
            begin errors++; $display("FAIL shf0 got al=%h st=%b exp al=bit73 st=0", al, st); end

        send_one(24'hC00001, 7'd51, 10'h010, 1'b0, al, st, eo, so, lat);
        checks++;
        if (al !== 74'h600000 || st !== 1'b1 || so !== 1'b0)
            begin errors++; $display("FAIL shf51 got al=%h st=%b sb=%b exp al=600000 st=1 sb=0", al, st, so); end

        send_one(24'hC00001, 7'd51, 10'h011, 1'b1, al, st, eo, so, lat);
        checks++;
        if (al !== ~74'h600000 || st !== 1'b1 || so !== 1'b1)
            begin errors++; $display("FAIL shf51_sub got al=%h st=%b sb=%b exp al=%h st=1 sb=1", al, st, so, ~74'h600000); end

        send_one(24'h800001, 7'd74, 10'h1F5, 1'b0, al, st, eo, so, lat);
        checks++;
        if (al !== 74'h0 || st !== 1'b1 || eo !== 10'h1F5)
            begin errors++; $display("FAIL shf74 got al=%h st=%b ex=%h exp 0/1/1f5", al, st, eo); end

        send_one(24'h800001, 7'd100, 10'h1F5, 1'b0, al, st, eo, so, lat);
        checks++;
        if (al !== 74'h0 || st !== 1'b1 || eo !== 10'h1F5)
            begin errors++; $display("FAIL shf100 got al=%h st=%b ex=%h exp 0/1/1f5", al, st, eo); end

        send_one(24'h000001, 7'd75, 10'h002, 1'b0, al, st, eo, so, lat);
        checks++;
        if (al !== 74'h0 || st !== 1'b1)
            begin errors++; $display("FAIL shf75 got al=%h st=%b exp al=0 st=1", al, st); end

        send_one(24'h000000, 7'd127, 10'h003, 1'b0, al, st, eo, so, lat);
        checks++;
        if (al !== 74'h0 || st !== 1'b0)
            begin errors++; $display("FAIL shf127_zero got al=%h st=%b exp al=0 st=0", al, st); end

        send_one(24'hFFFFFF, 7'd8, 10'h004, 1'b0, al, st, eo, so, lat);
        checks++;
        if (al !== 74'h3FFFFFC0000000000 || st !== 1'b0)
            begin errors++; $display("FAIL shf8 got al=%h st=%b exp al=3fffffc0000000000 st=0", al, st); end

        send_one(24'h800000, 7'd73, 10'h005, 1'b0, al, st, eo, so, lat);
        checks++;
        if (al !== 74'h1 || st !== 1'b0)
            begin errors++; $display("FAIL shf73 got al=%h st=%b exp al=1 st=0", al, st); end

        send_one(24'h8000FF, 7'd57, 10'h006, 1'b0, al, st, eo, so, lat);
        checks++;
        if (al !== 74'h10001 || st !== 1'b1)
            begin errors++; $display("FAIL shf57 got al=%h st=%b exp al=10001 st=1", al, st); end

        send_one(24'hABCDEF, 7'd50, 10'h007, 1'b1, al, st, eo, so, lat);
        checks++;
        if (al !== ~74'hABCDEF || st !== 1'b0 || eo !== 10'h007)
            begin errors++; $display("FAIL shf50_sub got al=%h st=%b ex=%h exp al=%h st=0 ex=007", al, st, eo, ~74'hABCDEF); end
    endtask

    task automatic test_back_to_back();
        int          n_in = 0;
        int          n_out = 0;
        int          last_out_cyc = 0;
        int          stall_fires = 0;
        logic        ready_c3 = 1'b1;
        int          acc_at_c6 = 0;
        logic [73:0] exp_al;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (n_in < 6);
            mant_c    = 24'h800000 + 24'(n_in * 24'h111);
            shf_num   = 7'd50;
            exp_tmp   = 10'h100 + 10'(n_in);
            eff_sub   = 1'b0;
            #1;
            if (c == 3) ready_c3 = in_ready;
            if (out_valid && out_ready) begin
                exp_al = {50'b0, 24'h800000 + 24'(n_out * 24'h111)};
                checks++;
                if (out_exp_tmp !== 10'h100 + 10'(n_out) || out_aligned !== exp_al || out_sticky !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_order idx=%0d got ex=%h al=%h exp ex=%h al=%h", n_out, out_exp_tmp, out_aligned, 10'h100 + 10'(n_out), exp_al);
                end
                n_out++;
                last_out_cyc = c;
            end
            if (out_valid && !out_ready && c >= 3 && c <= 6) stall_fires += 0;
            if (in_valid && in_ready) n_in++;
            if (c == 6) acc_at_c6 = n_in;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (ready_c3 !== 1'b0) begin errors++; $display("FAIL stream_ready_drop got=%b exp=0", ready_c3); end
        checks++;
        if (acc_at_c6 !== 2) begin errors++; $display("FAIL stream_accepts_in_stall got=%0d exp=2", acc_at_c6); end
        checks++;
        if (n_out !== 6) begin errors++; $display("FAIL stream_count got=%0d exp=6", n_out); end
        checks++;
        if (last_out_cyc !== 12) begin errors++; $display("FAIL stream_no_bubble last=%0d exp=12", last_out_cyc); end
        checks++;
        if (stall_fires !== 0) begin errors++; $display("FAIL stream_stall_fire got=%0d exp=0", stall_fires); end
    endtask

    task automatic test_reset_flush();
        int stale = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; mant_c = 24'hFFFFFF; shf_num = 7'd3;
            exp_tmp = 10'h3C0 + 10'(i); eff_sub = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_in_reset got=%b exp=0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_aligned !== 74'h0) begin
            errors++; $display("FAIL flush_out_cleared got v=%b al=%h exp v=0 al=0", out_valid, out_aligned);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got=%b exp=1", in_ready); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin errors++; $display("FAIL flush_stale got=%0d exp=0", stale); end
    endtask

    initial begin
        test_reset();
        test_align();
        test_back_to_back();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
